// File: rtl/freq_spi_pkg.sv
// Shared definitions for the frequency-word SPI writer.
// Contents:
//   spiState_t - sequencing states shared by the top level and the frame serializer
//   WORD_W     - bits per SPI register frame
//   N_FRAMES   - frames per frequency word (upper half, then lower half)
//   cntWidth   - counter width for a terminal count, never narrower than one bit
package freq_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    DONE
  } spiState_t;

  localparam int WORD_W   = 16;
  localparam int N_FRAMES = 2;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_spi_writer_spi_word_tx.sv
// Serializes one 16-bit register frame as a mode-0, MSB-first SPI master.
// A frame is SETUP (CLK_DIV cycles, csn low, sclk low, first bit on mosi),
// 16 bits of CLK_DIV low + CLK_DIV high sclk, then HOLD (CLK_DIV cycles low).
// Ports:
//   clk, rstn  - system clock, asynchronous active-low reset
//   go         - start a frame; only honoured while the serializer is idle
//   word       - frame data, captured on go
//   frameDone  - high in the final HOLD cycle; csn rises on the next edge
//   csn        - chip select, active-low (registered)
//   sclk       - serial clock, idle low (registered)
//   mosi       - serial data, 0 while csn is high (registered)
import freq_spi_pkg::*;

module spi_word_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  input  logic [WORD_W-1:0] word,
  output logic              frameDone,
  output logic              csn,
  output logic              sclk,
  output logic              mosi
);

  localparam int HW = cntWidth(CLK_DIV);

  spiState_t         state, stateNext;
  logic [HW-1:0]     halfCnt, halfNext;
  logic [3:0]        bitCnt, bitNext;
  logic [WORD_W-1:0] shiftReg, shiftNext;
  logic              csnNext, sclkNext, mosiNext;
  logic              halfLast;

  assign halfLast  = (halfCnt == HW'(CLK_DIV - 1));
  assign frameDone = (state == HOLD) && halfLast;

  // State, counters and the three SPI pins are all plain flops so the pins
  // leave the block glitch-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      halfCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      csn      <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state    <= stateNext;
      halfCnt  <= halfNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      csn      <= csnNext;
      sclk     <= sclkNext;
      mosi     <= mosiNext;
    end
  end

  // Next-state and next-pin logic. The current sclk level doubles as the
  // low/high phase flag inside SHIFT. The shift register always holds the
  // bit on the wire in its MSB, so the next bit is taken from MSB-1 at the
  // end of each high phase, which is also the start of the next low phase.
  always_comb begin
    stateNext = state;
    halfNext  = halfCnt;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    csnNext   = csn;
    sclkNext  = sclk;
    mosiNext  = mosi;
    case (state)
      IDLE: begin
        csnNext  = 1'b1;
        sclkNext = 1'b0;
        mosiNext = 1'b0;
        if (go) begin
          stateNext = SETUP;
          halfNext  = '0;
          shiftNext = word;
          csnNext   = 1'b0;
          mosiNext  = word[WORD_W-1];
        end
      end
      SETUP: begin
        halfNext = halfCnt + 1'b1;
        if (halfLast) begin
          halfNext  = '0;
          bitNext   = 4'(WORD_W - 1);
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        halfNext = halfCnt + 1'b1;
        if (halfLast) begin
          halfNext = '0;
          if (!sclk) begin
            sclkNext = 1'b1;
          end else begin
            sclkNext = 1'b0;
            if (bitCnt == 4'd0) begin
              stateNext = HOLD;
            end else begin
              bitNext   = bitCnt - 4'd1;
              shiftNext = shiftReg << 1;
              mosiNext  = shiftReg[WORD_W-2];
            end
          end
        end
      end
      HOLD: begin
        halfNext = halfCnt + 1'b1;
        if (halfLast) begin
          halfNext  = '0;
          stateNext = IDLE;
          csnNext   = 1'b1;
          mosiNext  = 1'b0;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/freq_spi_writer.sv
// Writes a 32-bit frequency word to the RF synthesizer as two SPI frames,
// upper half first, separated by GAP_CYC cycles of csn high.
// Ports:
//   clk, rstn  - system clock, asynchronous active-low reset
//   start      - one-cycle request, accepted only while busy is low
//   freq_data  - frequency word, captured into a shadow register on accept
//   busy       - transfer in progress (registered)
//   done       - one-cycle pulse in the cycle after the last frame (registered)
//   spi_csn    - chip select, active-low
//   spi_sclk   - serial clock, idle low
//   spi_mosi   - serial data
import freq_spi_pkg::*;

module freq_spi_writer #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] freq_data,
  output logic        busy,
  output logic        done,
  output logic        spi_csn,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam int GW = cntWidth(GAP_CYC);

  // SHIFT here means "a frame is in flight inside the serializer".
  spiState_t         state, stateNext;
  logic [31:0]       shadow, shadowNext;
  logic              frameIdx, frameNext;
  logic [GW-1:0]     gapCnt, gapNext;
  logic              busyNext, doneNext;
  logic              go;
  logic [WORD_W-1:0] goWord;
  logic              frameDone;
  logic              gapLast;

  assign gapLast = (gapCnt == GW'(GAP_CYC - 1));

  // Sequencing registers plus the busy/done output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shadow   <= '0;
      frameIdx <= 1'b0;
      gapCnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      shadow   <= shadowNext;
      frameIdx <= frameNext;
      gapCnt   <= gapNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

  // Frame sequencing. DONE behaves like IDLE so a start in the done cycle
  // launches the next transfer without an idle cycle. The first frame is
  // fed straight from freq_data because the shadow only loads on this edge.
  always_comb begin
    stateNext  = state;
    shadowNext = shadow;
    frameNext  = frameIdx;
    gapNext    = gapCnt;
    busyNext   = busy;
    doneNext   = 1'b0;
    go         = 1'b0;
    goWord     = shadow[WORD_W-1:0];
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
        if (start) begin
          stateNext  = SHIFT;
          shadowNext = freq_data;
          frameNext  = 1'b0;
          busyNext   = 1'b1;
          go         = 1'b1;
          goWord     = freq_data[31:WORD_W];
        end
      end
      SHIFT: begin
        if (frameDone) begin
          if (frameIdx == 1'(N_FRAMES - 1)) begin
            stateNext = DONE;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            stateNext = GAP;
            gapNext   = '0;
          end
        end
      end
      GAP: begin
        gapNext = gapCnt + 1'b1;
        if (gapLast) begin
          gapNext   = '0;
          go        = 1'b1;
          frameNext = 1'b1;
          stateNext = SHIFT;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  spi_word_tx #(
    .CLK_DIV(CLK_DIV)
  ) wordTx (
    .clk      (clk),
    .rstn     (rstn),
    .go       (go),
    .word     (goWord),
    .frameDone(frameDone),
    .csn      (spi_csn),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi)
  );

endmodule

// File: tb/tb_freq_spi_writer.sv
// Self-checking bench for freq_spi_writer. Two instances share all inputs:
// dut0 uses CLK_DIV=4/GAP_CYC=8, dut1 uses CLK_DIV=2/GAP_CYC=1. A cycle-level
// model computes every output from the offset since the accepted start.
module tb_freq_spi_writer;

  localparam int DIV0 = 4;
  localparam int GAP0 = 8;
  localparam int DIV1 = 2;
  localparam int GAP1 = 1;

  typedef struct packed {
    logic busy;
    logic done;
    logic csn;
    logic sclk;
    logic mosi;
    logic mosiCare;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] freq_data;
  wire  [1:0]  busyV, doneV, csnV, sclkV, mosiV;

  int          cyc;
  int          errors;
  int          checks;
  bit          act      [2];
  int          tAcc     [2];
  logic [31:0] wAcc     [2];
  logic        prevSclk [2];
  logic        prevCsn  [2];
  int          edgeCnt  [2];
  int          lowLen   [2];
  int          doneCnt  [2];
  int          lastDone [2];
  int          lastFall [2];
  logic [15:0] capWord  [2];
  logic [15:0] capQ0[$];
  logic [15:0] capQ1[$];
  int          lenQ0[$];
  int          lenQ1[$];

  freq_spi_writer #(.CLK_DIV(DIV0), .GAP_CYC(GAP0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .freq_data(freq_data),
    .busy(busyV[0]), .done(doneV[0]), .spi_csn(csnV[0]),
    .spi_sclk(sclkV[0]), .spi_mosi(mosiV[0])
  );

  freq_spi_writer #(.CLK_DIV(DIV1), .GAP_CYC(GAP1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .freq_data(freq_data),
    .busy(busyV[1]), .done(doneV[1]), .spi_csn(csnV[1]),
    .spi_sclk(sclkV[1]), .spi_mosi(mosiV[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t idleExp();
    exp_t e;
    e = '0;
    e.csn      = 1'b1;
    e.mosiCare = 1'b1;
    return e;
  endfunction

  // Pins during one frame, j cycles after csn fell.
  function automatic exp_t frameOut(input int j, input logic [15:0] w16, input int d);
    exp_t e;
    int   b;
    int   ph;
    e = idleExp();
    e.busy = 1'b1;
    e.csn  = 1'b0;
    if (j < d) begin
      e.mosi = w16[15];
    end else if (j < 33 * d) begin
      b      = (j - d) / (2 * d);
      ph     = (j - d) % (2 * d);
      e.sclk = (ph >= d);
      e.mosi = w16[15 - b];
    end else begin
      e.mosiCare = 1'b0;
    end
    return e;
  endfunction

  // Outputs k cycles after the start was accepted (k=0 means idle).
  function automatic exp_t modelOut(input int k, input logic [31:0] w, input int d, input int g);
    exp_t e;
    int   fl;
    fl = 34 * d;
    e  = idleExp();
    if (k >= 1 && k <= fl) e = frameOut(k - 1, w[31:16], d);
    else if (k > fl && k <= fl + g) e.busy = 1'b1;
    else if (k > fl + g && k <= 2 * fl + g) e = frameOut(k - fl - g - 1, w[15:0], d);
    else if (k == 2 * fl + g + 1) e.done = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int i, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0h want %0h", name, i, cyc, got, want);
    end
  endtask

  task automatic compareOne(input int i);
    exp_t e;
    int   k;
    logic b, d, cs, sc, mo;
    b  = busyV[i];
    d  = doneV[i];
    cs = csnV[i];
    sc = sclkV[i];
    mo = mosiV[i];
    if (!rstn) begin
      e      = idleExp();
      act[i] = 1'b0;
    end else begin
      k = act[i] ? (cyc - tAcc[i]) : 0;
      e = modelOut(k, wAcc[i], (i == 0) ? DIV0 : DIV1, (i == 0) ? GAP0 : GAP1);
    end
    checkOutput("busy", i, b, e.busy);
    checkOutput("done", i, d, e.done);
    checkOutput("csn", i, cs, e.csn);
    checkOutput("sclk", i, sc, e.sclk);
    if (e.mosiCare) checkOutput("mosi", i, mo, e.mosi);

    if (!prevSclk[i] && sc) begin
      checkOutput("sclkRiseCsn", i, cs, 1'b0);
      edgeCnt[i]++;
      capWord[i] = {capWord[i][14:0], mo};
    end
    if (cs != prevCsn[i]) begin
      checkOutput("sclkAtCsnEdge", i, {prevSclk[i], sc}, 2'b00);
      if (!cs) begin
        edgeCnt[i]  = 0;
        lastFall[i] = cyc;
      end else if (rstn) begin
        checkOutput("edgeCount", i, edgeCnt[i], 16);
        if (i == 0) begin
          capQ0.push_back(capWord[i]);
          lenQ0.push_back(lowLen[i]);
        end else begin
          capQ1.push_back(capWord[i]);
          lenQ1.push_back(lowLen[i]);
        end
      end
    end
    if (!cs) lowLen[i] = prevCsn[i] ? 1 : lowLen[i] + 1;
    if (d) begin
      doneCnt[i]++;
      lastDone[i] = cyc;
    end
    if (rstn && start && !e.busy) begin
      act[i]  = 1'b1;
      tAcc[i] = cyc;
      wAcc[i] = freq_data;
    end
    prevSclk[i] = sc;
    prevCsn[i]  = cs;
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) compareOne(i);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic s, input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    start     = s;
    freq_data = d;
    rstn      = r;
  endtask

  task automatic checkFrames(input int i, input int base, input logic [31:0] w);
    int n;
    n = (i == 0) ? capQ0.size() : capQ1.size();
    checkOutput("frameCount", i, n - base, 2);
    if (n >= base + 2) begin
      checkOutput("frameHi", i, (i == 0) ? capQ0[base] : capQ1[base], w[31:16]);
      checkOutput("frameLo", i, (i == 0) ? capQ0[base+1] : capQ1[base+1], w[15:0]);
      checkOutput("csnLowLen", i, (i == 0) ? lenQ0[base] : lenQ1[base], 34 * ((i == 0) ? DIV0 : DIV1));
      checkOutput("csnLowLen", i, (i == 0) ? lenQ0[base+1] : lenQ1[base+1], 34 * ((i == 0) ? DIV0 : DIV1));
    end
  endtask

  task automatic checkDone(input int i, input int base, input int tS, input int lat);
    checkOutput("doneCount", i, doneCnt[i] - base, 1);
    checkOutput("doneLatency", i, lastDone[i] - tS, lat);
  endtask

  initial begin
    exp_t p;
    int   tS, d0, d1, q0, q1;
    rstn      = 1'b1;
    start     = 1'b0;
    freq_data = '0;
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    for (int i = 0; i < 2; i++) begin
      act[i]      = 1'b0;
      tAcc[i]     = 0;
      wAcc[i]     = '0;
      prevSclk[i] = 1'b0;
      prevCsn[i]  = 1'b1;
      edgeCnt[i]  = 0;
      lowLen[i]   = 0;
      doneCnt[i]  = 0;
      lastDone[i] = 0;
      lastFall[i] = 0;
      capWord[i]  = '0;
    end
    #1 rstn = 1'b0;
    fork
      compareLoop();
    join_none

    // Hand-computed points that pin the model.
    p = modelOut(281, 32'h0c000d3c, 4, 8); checkOutput("pinDoneAt281", 0, p.done, 1'b1);
    p = modelOut(280, 32'h0c000d3c, 4, 8); checkOutput("pinCsnAt280", 0, p.csn, 1'b0);
    p = modelOut(137, 32'h0c000d3c, 4, 8); checkOutput("pinGapAt137", 0, {p.busy, p.csn}, 2'b11);
    p = modelOut(9, 32'h0c000d3c, 4, 8);   checkOutput("pinFirstRise", 0, p.sclk, 1'b1);
    p = modelOut(8, 32'h0c000d3c, 4, 8);   checkOutput("pinLowAt8", 0, p.sclk, 1'b0);
    p = modelOut(41, 32'h0c000d3c, 4, 8);  checkOutput("pinBit11", 0, {p.sclk, p.mosi}, 2'b11);
    p = modelOut(138, 32'h0cf00d3f, 2, 1); checkOutput("pinDoneAt138", 1, p.done, 1'b1);

    // Reset state.
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rstBusy", 0, busyV, 2'b00);
    checkOutput("rstDone", 0, doneV, 2'b00);
    checkOutput("rstCsn", 0, csnV, 2'b11);
    checkOutput("rstSclk", 0, sclkV, 2'b00);
    checkOutput("rstMosi", 0, mosiV, 2'b00);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);

    // Basic transfer with freq_data changed at T+10 and start at T+50.
    d0 = doneCnt[0]; d1 = doneCnt[1]; q0 = capQ0.size(); q1 = capQ1.size();
    applyStimulus(1'b1, 32'h0c000d3c, 1'b1);
    tS = cyc + 1;
    repeat (9) applyStimulus(1'b0, 32'h0c000d3c, 1'b1);
    repeat (40) applyStimulus(1'b0, 32'hffffffff, 1'b1);
    applyStimulus(1'b1, 32'hffffffff, 1'b1);
    repeat (240) applyStimulus(1'b0, 32'hffffffff, 1'b1);
    checkDone(0, d0, tS, 281);
    checkDone(1, d1, tS, 138);
    checkFrames(0, q0, 32'h0c000d3c);
    checkFrames(1, q1, 32'h0c000d3c);

    // Second word with mixed nibbles.
    d0 = doneCnt[0]; d1 = doneCnt[1]; q0 = capQ0.size(); q1 = capQ1.size();
    applyStimulus(1'b1, 32'h0cf00d3f, 1'b1);
    tS = cyc + 1;
    repeat (290) applyStimulus(1'b0, 32'h0, 1'b1);
    checkDone(0, d0, tS, 281);
    checkDone(1, d1, tS, 138);
    checkFrames(0, q0, 32'h0cf00d3f);
    checkFrames(1, q1, 32'h0cf00d3f);

    // Start in the done cycle: dut1 at T+138, dut0 at T+281.
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    tS = cyc + 1;
    repeat (137) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("b2bDone", 1, lastDone[1] - tS, 138);
    checkOutput("b2bFall", 1, lastFall[1] - lastDone[1], 1);
    repeat (139) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'ha5a5c3c3, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("b2bDone", 0, lastDone[0] - tS, 281);
    checkOutput("b2bFall", 0, lastFall[0] - lastDone[0], 1);
    q0 = capQ0.size(); q1 = capQ1.size();
    repeat (300) applyStimulus(1'b0, 32'h0, 1'b1);
    checkFrames(0, q0, 32'ha5a5c3c3);
    checkFrames(1, q1, 32'ha5a5c3c3);

    // Reset at T+70 abandons the transfer immediately.
    d0 = doneCnt[0]; d1 = doneCnt[1];
    applyStimulus(1'b1, 32'h0c000d3c, 1'b1);
    repeat (69) applyStimulus(1'b0, 32'h0c000d3c, 1'b1);
    applyStimulus(1'b0, 32'h0c000d3c, 1'b0);
    #1;
    checkOutput("asyncRstCsn", 0, csnV, 2'b11);
    checkOutput("asyncRstSclk", 0, sclkV, 2'b00);
    checkOutput("asyncRstMosi", 0, mosiV, 2'b00);
    checkOutput("asyncRstBusy", 0, busyV, 2'b00);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (300) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("noDoneAfterRst", 0, doneCnt[0] - d0, 0);
    checkOutput("noDoneAfterRst", 1, doneCnt[1] - d1, 0);
    d0 = doneCnt[0]; d1 = doneCnt[1]; q0 = capQ0.size(); q1 = capQ1.size();
    applyStimulus(1'b1, 32'h5aa53cc3, 1'b1);
    tS = cyc + 1;
    repeat (290) applyStimulus(1'b0, 32'h0, 1'b1);
    checkDone(0, d0, tS, 281);
    checkDone(1, d1, tS, 138);
    checkFrames(0, q0, 32'h5aa53cc3);
    checkFrames(1, q1, 32'h5aa53cc3);

    // Random starts and data, including starts while busy.
    repeat (3000) applyStimulus($urandom_range(0, 15) == 0, $urandom, 1'b1);
    repeat (300) applyStimulus(1'b0, $urandom, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
